// File: rtl/gray_pkg.sv
// Shared Gray-code definitions for the pointer counter and its partners.
//   GRAY_DEFAULT_WIDTH : default counter width
//   GRAY_MAX_WIDTH     : widest value bin2gray() accepts
//   bin2gray(bin)      : reflected binary Gray encode. The caller zero-extends
//                        to GRAY_MAX_WIDTH and truncates the result to its own
//                        width, so one function serves every width.
package gray_pkg;

    localparam int GRAY_DEFAULT_WIDTH = 4;
    localparam int GRAY_MAX_WIDTH     = 64;

    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(
        input logic [GRAY_MAX_WIDTH-1:0] bin
    );
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/bin2gray_comb.sv
// Combinational binary-to-Gray encoder. Encode-side mirror of the Gray-to-binary
// decoder; also usable directly by FIFO full/empty compare logic.
//   bin  : binary input, WIDTH bits
//   gray : Gray code of bin, WIDTH bits
module bin2gray_comb
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    // Upper zero bits contribute nothing, so truncation is exact.
    assign gray = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(bin)));

endmodule

// File: rtl/gray_ptr_counter.sv
// Registered binary/Gray pointer counter for async FIFO pointers and
// cross-domain event counters. gray_out comes straight from a flop so it is
// safe to synchronise into another clock domain.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear, highest priority, never raises wrap
//   inc        : advance one step this cycle
//   dn         : direction, 1 = down (only with GRAY_CNT_DOWN_EN)
//   bin_out    : registered binary count
//   gray_out   : registered Gray code of bin_out
//   gray_next  : combinational Gray code of the value loaded at the next edge
//   wrap       : registered one-cycle pulse on rollover in the active direction
// Configuration macro: GRAY_CNT_DOWN_EN adds the dn port and down counting.
module gray_ptr_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] gray_next,
    output logic             wrap
`ifdef GRAY_CNT_DOWN_EN
    ,
    input  logic             dn
`endif
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             dn_w;
    logic [WIDTH-1:0] bin_d, bin_q;
    logic [WIDTH-1:0] gray_d, gray_q;
    logic             wrap_d, wrap_q;

`ifdef GRAY_CNT_DOWN_EN
    assign dn_w = dn;
`else
    assign dn_w = 1'b0;
`endif

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (clr) begin
            bin_d = '0;
        end else if (inc) begin
            if (dn_w) begin
                bin_d  = bin_q - ONE;
                wrap_d = (bin_q == '0);
            end else begin
                bin_d  = bin_q + ONE;
                wrap_d = &bin_q;
            end
        end
    end

    // Gray is encoded from bin_d and registered alongside it, so the
    // registered pair is always consistent.
    bin2gray_comb #(.WIDTH(WIDTH)) u_enc (
        .bin  (bin_d),
        .gray (gray_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin_out   = bin_q;
    assign gray_out  = gray_q;
    assign gray_next = gray_d;
    assign wrap      = wrap_q;

endmodule

// File: doc/gray_ptr_counter.md
# gray_ptr_counter

Registered binary-to-Gray pointer counter. Keeps a WIDTH-bit binary count and, on the same clock edge, a Gray-coded copy that changes exactly one bit per step. The Gray value is driven directly from a flop, so it can safely cross clock domains. It is the encode-side partner of the team's Gray-to-binary decoder and serves as the read/write pointer source for async FIFOs and cross-domain event counters.

## Interface
Parameters:
- WIDTH, 4, counter width in bits (≥2)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- clr  input  1  synchronous clear to zero; overrides all other controls
- inc  input  1  advance the count by one step this cycle
- bin_out  output  WIDTH  registered binary count
- gray_out  output  WIDTH  registered Gray code of bin_out
- gray_next  output  WIDTH  combinational Gray code of the value that will be loaded at the next edge
- wrap  output  1  registered one-cycle pulse on terminal-count rollover
- dn  input  1  count direction, 1 = down (only present with GRAY_CNT_DOWN_EN)

## Operation
- bin_next is selected by priority:
  - clr → 0
  - else inc → bin_out+1 (or bin_out−1 when dn=1), modulo 2^WIDTH
  - else hold
- gray_next = bin_next ^ (bin_next >> 1); no other encoding is allowed.
- bin_out and gray_out load bin_next and gray_next on the same edge, so gray_out == bin_out ^ (bin_out>>1) holds in every cycle.
- wrap is registered as 1 when the counter rolls over in the active direction:
  - inc with dn=0 and bin_out = 2^WIDTH−1 (next value 0)
  - inc with dn=1 and bin_out = 0 (next value 2^WIDTH−1)
  - otherwise 0
- clr never asserts wrap, even when bin_out is at terminal count.
- clr and inc asserted together: the clear wins and the increment is dropped.
- Each inc step changes gray_out in exactly one bit, including across the wrap.
- No internal state exists beyond bin_out, gray_out and wrap.

## Timing
- Reset (rst_n low, asynchronous): bin_out=0, gray_out=0, wrap=0. Release is synchronous to the next clk edge.
- Reset asserted mid-count returns all outputs to 0 immediately, without waiting for a clock edge.
- Latency: one clk from inc/clr to bin_out/gray_out/wrap. gray_next has zero latency (combinational from inputs and current state).
- wrap is high for exactly one cycle per rollover. With inc held continuously, wrap pulses every 2^WIDTH cycles.
- Back-to-back inc every cycle is supported; there is no handshake and no stall.

## Configuration
- GRAY_CNT_DOWN_EN defined:
  - the dn port exists and bidirectional counting is enabled
  - wrap covers both rollover directions
- GRAY_CNT_DOWN_EN undefined:
  - no dn port; up-count only
  - wrap covers only max→0
  - all other behaviour is identical

## Structure
- Shared package gray_pkg holds:
  - pure function bin2gray(bin), parameterised by width through the caller
  - the constant GRAY_DEFAULT_WIDTH = 4
- Sub-module bin2gray_comb (WIDTH parameter, input bin, output gray) produces gray_next. It is the structural mirror of the existing Gray-to-binary decoder and is reusable by FIFO full/empty logic.
- The counter register, wrap logic and direction mux live in gray_ptr_counter.

## Test plan
All scenarios use WIDTH=4.
- Reset: drive rst_n=0 mid-count at bin_out=5, with no clk edge → bin_out=0, gray_out=0, wrap=0 immediately.
- Up-count: hold inc=1 for 16 cycles from 0 → gray_out sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0. Exactly one bit changes per step, and wrap=1 only in the cycle after bin 15→0.
- Hold and lookahead: at bin_out=7, inc=0 for 3 cycles → outputs stable at bin 7 / gray 4. Then assert inc=1 → gray_next=C in that cycle and gray_out=C after the edge.
- Clear priority: at bin_out=15, assert clr=1 and inc=1 together → bin_out=0, gray_out=0, wrap stays 0.
- Down-count (GRAY_CNT_DOWN_EN): from 0 with dn=1, inc=1 → bin_out=15, gray_out=8, wrap=1 for one cycle. The next step gives bin 14 / gray 9.
- Invariant check: random inc/clr/dn for 10k cycles. gray_out must equal bin_out^(bin_out>>1) every cycle, and the Hamming distance between consecutive gray_out values must be ≤1 except on clr.
